// File: rtl/t_mac_array.sv
// rtl/t_mac_array.sv - ternary multiply-accumulate array with pipelined adder tree and beat accumulator
module t_mac_array #(
    parameter int Tn            = 2,
    parameter int Tm            = 2,
    parameter int KERNEL_SIZE   = 3,
    parameter int FEATURE_WIDTH = 8,
    parameter int KERNEL_WIDTH  = 2,
    parameter int OUT_WIDTH     = 20
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [Tn*KERNEL_SIZE*KERNEL_SIZE*FEATURE_WIDTH-1:0]    feature_in,
    input  logic                                            feature_valid,
    input  logic                                            feature_last,
    input  logic                                            kernel_valid,
    input  logic [Tm*Tn*KERNEL_SIZE*KERNEL_SIZE*KERNEL_WIDTH-1:0] weight_in,
    output logic [Tm*OUT_WIDTH-1:0]                         sum_out,
    output logic                                            sum_valid,
    output logic                                            busy
);

    localparam int N      = Tn * KERNEL_SIZE * KERNEL_SIZE;
    localparam int LEVELS = (N > 1) ? $clog2(N) : 1;
    localparam int P      = 1 << LEVELS;

    function automatic logic signed [OUT_WIDTH-1:0] select_term(
        input logic [FEATURE_WIDTH-1:0] f,
        input logic [KERNEL_WIDTH-1:0]  w
    );
        logic signed [OUT_WIDTH-1:0] fx;
        // Widen before negating so -(-2^(FW-1)) is representable.
        fx = {{(OUT_WIDTH-FEATURE_WIDTH){f[FEATURE_WIDTH-1]}}, f};
        case (w)
            2'b01:   return fx;
            2'b11:   return -fx;
            default: return '0;
        endcase
    endfunction

    logic [KERNEL_WIDTH-1:0] w_bank [Tm*N];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < Tm*N; j++) w_bank[j] <= '0;
        end else if (kernel_valid) begin
            for (int j = 0; j < Tm*N; j++) w_bank[j] <= weight_in[j*KERNEL_WIDTH +: KERNEL_WIDTH];
        end
    end

    logic signed [OUT_WIDTH-1:0] s1_term [Tm][N];
    logic                        s1_valid;
    logic                        s1_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            for (int m = 0; m < Tm; m++)
                for (int i = 0; i < N; i++) s1_term[m][i] <= '0;
        end else begin
            s1_valid <= feature_valid;
            s1_last  <= feature_valid & feature_last;
            for (int m = 0; m < Tm; m++)
                for (int i = 0; i < N; i++)
                    s1_term[m][i] <= select_term(feature_in[i*FEATURE_WIDTH +: FEATURE_WIDTH],
                                                 w_bank[m*N+i]);
        end
    end

    logic [LEVELS:0] lvl_vld;

    // Binary reduction; a register sits after every second level and after the root.
    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int  W      = 1 << (LEVELS - l);
        localparam bit  IS_REG = (l % 2 == 0) || (l == LEVELS);
        logic signed [OUT_WIDTH-1:0] val [Tm][W];
        logic                        vld;
        logic                        lst;

        assign lvl_vld[l] = vld;

        if (l == 0) begin : g_leaf
            assign vld = s1_valid;
            assign lst = s1_last;
            for (genvar m = 0; m < Tm; m++) begin : g_m
                for (genvar i = 0; i < P; i++) begin : g_i
                    if (i < N) begin : g_use
                        assign val[m][i] = s1_term[m][i];
                    end else begin : g_pad
                        assign val[m][i] = '0;
                    end
                end
            end
        end else if (IS_REG) begin : g_reg
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld <= 1'b0;
                    lst <= 1'b0;
                    for (int m = 0; m < Tm; m++)
                        for (int i = 0; i < W; i++) val[m][i] <= '0;
                end else begin
                    vld <= g_lvl[l-1].vld;
                    lst <= g_lvl[l-1].lst;
                    for (int m = 0; m < Tm; m++)
                        for (int i = 0; i < W; i++)
                            val[m][i] <= g_lvl[l-1].val[m][2*i] + g_lvl[l-1].val[m][2*i+1];
                end
            end
        end else begin : g_comb
            always_comb begin
                vld = g_lvl[l-1].vld;
                lst = g_lvl[l-1].lst;
                for (int m = 0; m < Tm; m++)
                    for (int i = 0; i < W; i++)
                        val[m][i] = g_lvl[l-1].val[m][2*i] + g_lvl[l-1].val[m][2*i+1];
            end
        end
    end

    logic signed [OUT_WIDTH-1:0] acc      [Tm];
    logic signed [OUT_WIDTH-1:0] acc_next [Tm];
    logic                        grp_open;

    always_comb begin
        for (int m = 0; m < Tm; m++)
            acc_next[m] = (grp_open ? acc[m] : '0) + g_lvl[LEVELS].val[m][0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grp_open  <= 1'b0;
            sum_valid <= 1'b0;
            sum_out   <= '0;
            for (int m = 0; m < Tm; m++) acc[m] <= '0;
        end else begin
            sum_valid <= 1'b0;
            if (g_lvl[LEVELS].vld) begin
                grp_open  <= ~g_lvl[LEVELS].lst;
                sum_valid <= g_lvl[LEVELS].lst;
                for (int m = 0; m < Tm; m++) begin
                    acc[m] <= acc_next[m];
                    if (g_lvl[LEVELS].lst) sum_out[m*OUT_WIDTH +: OUT_WIDTH] <= acc_next[m];
                end
            end
        end
    end

    assign busy = (|lvl_vld) | grp_open;

endmodule
